// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: arbiter state encoding and default channel geometry.
//   state_t : IDLE (no grant) / BUSY (grant held on grant_idx)
//   DEF_N   : default number of requesters
//   DEF_W   : default data width per requester
package mux_arb_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority search, first set bit of req at or above start, wrapping modulo N.
//   req   : candidate request mask
//   start : index where the search begins
//   found : some bit of req is set
//   idx   : winning index (equals start when nothing is found)
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    // Walk offsets from the far end down so the nearest offset is written last and wins;
    // N is a power of two, so the IW-bit add wraps modulo N for free.
    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[start + IW'(i)]) begin
                found = 1'b1;
                idx   = start + IW'(i);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin N:1 valid/ready multiplexer onto one shared channel.
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester valid (N)
//   req_data   : packed requester data, lane i at [i*W +: W]
//   req_ready  : per-requester ready, one-hot or zero
//   out_valid  : shared-channel valid, high while a grant is held
//   out_data   : data of the granted requester, zero while idle
//   out_ready  : downstream ready
//   grant_idx  : current or last granted requester
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    state_t          r_state;
    state_t          w_nstate;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_nptr;
    logic [IW-1:0]   r_grant;
    logic [IW-1:0]   w_ngrant;
    logic            w_busy;
    logic            w_xfer;
    logic [N-1:0]    w_onehot;
    logic [N-1:0]    w_mask;
    logic [IW-1:0]   w_start;
    logic            w_found;
    logic [IW-1:0]   w_idx;

    assign w_busy   = (r_state == BUSY);
    assign w_xfer   = w_busy && out_ready;
    assign w_onehot = N'(1) << r_grant;

    // On a transfer the search restarts just past the granted requester with its bit masked,
    // so the next grant can issue in the same cycle without regranting the one just served.
    assign w_mask  = w_xfer ? (req_valid & ~w_onehot) : req_valid;
    assign w_start = w_xfer ? r_grant + IW'(1) : r_ptr;

    rr_pick #(.N(N)) u_pick (
        .req   (w_mask),
        .start (w_start),
        .found (w_found),
        .idx   (w_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_nstate;
            r_ptr   <= w_nptr;
            r_grant <= w_ngrant;
        end
    end

    // A held grant (busy, no ready) keeps everything; only idle or a transfer re-arbitrates.
    always_comb begin
        w_nstate = r_state;
        w_nptr   = r_ptr;
        w_ngrant = r_grant;
        if (w_xfer) begin
            w_nptr   = w_start;
            w_nstate = IDLE;
        end
        if ((!w_busy || w_xfer) && w_found) begin
            w_nstate = BUSY;
            w_ngrant = w_idx;
        end
    end

    assign out_valid = w_busy;
    assign out_data  = w_busy ? req_data[W*int'(r_grant) +: W] : W'(0);
    assign req_ready = w_xfer ? w_onehot : '0;
    assign grant_idx = r_grant;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed self-checking bench for mux_rr_arbiter (N=4, W=8).
module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [1:0]     grant_idx;

    int n_chk = 0;
    int n_err = 0;

    mux_rr_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    // Requesters must hold valid until they see ready.
    logic [N-1:0] r_pend  = '0;
    logic         r_rst_q = 1'b1;
    always @(posedge clk) begin
        if (!rst && !r_rst_q)
            assert ((r_pend & ~req_valid) == '0) else $error("protocol violation: valid dropped before ready");
        r_pend  <= req_valid & ~req_ready;
        r_rst_q <= rst;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        out_ready = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [N*W-1:0] d_lanes;
    logic [N*W-1:0] d_030;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        d_lanes   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        d_030     = {8'h33, 8'h22, 8'h11, 8'h00};

        // reset state, including with requests and ready applied during reset
        repeat (2) @(negedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst grant_idx", 32'(grant_idx), 0);
        check("rst req_ready", 32'(req_ready), 0);
        check("rst out_data", 32'(out_data), 0);
        drive(4'b1111, d_lanes, 1'b1);
        check("rst hold out_valid", 32'(out_valid), 0);
        check("rst hold req_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;

        // single request on lane 2
        drive(4'b0100, {8'h00, 8'h5A, 8'h00, 8'h00}, 1'b1);
        check("028 latency", 32'(out_valid), 0);
        drive(4'b0100, {8'h00, 8'h5A, 8'h00, 8'h00}, 1'b1);
        check("028 out_valid", 32'(out_valid), 1);
        check("028 grant", 32'(grant_idx), 2);
        check("028 data", 32'(out_data), 32'h5A);
        check("028 ready", 32'(req_ready), 32'b0100);
        drive(4'b0000, '0, 1'b1);
        check("028 idle", 32'(out_valid), 0);
        check("028 ready off", 32'(req_ready), 0);
        check("028 idle data", 32'(out_data), 0);

        // all requesters continuously valid: 0,1,2,3,0 back to back
        do_reset();
        drive(4'b1111, d_lanes, 1'b1);
        check("029 latency", 32'(out_valid), 0);
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, d_lanes, 1'b1);
            check($sformatf("029 valid %0d", k), 32'(out_valid), 1);
            check($sformatf("029 grant %0d", k), 32'(grant_idx), k % 4);
            check($sformatf("029 data %0d", k), 32'(out_data), 32'hA0 + (k % 4));
            check($sformatf("029 ready %0d", k), 32'(req_ready), 32'(1) << (k % 4));
        end

        // grant 1 held under backpressure, then 3, then 0
        do_reset();
        drive(4'b0010, d_030, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(4'b1011, d_030, 1'b0);
            check($sformatf("030 hold grant %0d", k), 32'(grant_idx), 1);
            check($sformatf("030 hold data %0d", k), 32'(out_data), 32'h11);
            check($sformatf("030 hold ready %0d", k), 32'(req_ready), 0);
        end
        drive(4'b1011, d_030, 1'b1);
        check("030 xfer ready", 32'(req_ready), 32'b0010);
        drive(4'b1001, d_030, 1'b1);
        check("030 next grant", 32'(grant_idx), 3);
        check("030 next data", 32'(out_data), 32'h33);
        drive(4'b0001, d_030, 1'b1);
        check("030 wrap grant", 32'(grant_idx), 0);
        check("030 wrap valid", 32'(out_valid), 1);
        drive(4'b0000, d_030, 1'b1);
        check("030 idle", 32'(out_valid), 0);

        // lone requester 3: grant, idle bubble, grant again
        do_reset();
        drive(4'b1000, d_030, 1'b1);
        check("031 latency", 32'(out_valid), 0);
        drive(4'b1000, d_030, 1'b1);
        check("031 grant a", 32'(grant_idx), 3);
        check("031 valid a", 32'(out_valid), 1);
        drive(4'b1000, d_030, 1'b1);
        check("031 bubble", 32'(out_valid), 0);
        drive(4'b1000, d_030, 1'b1);
        check("031 grant b", 32'(grant_idx), 3);
        check("031 valid b", 32'(out_valid), 1);
        drive(4'b1000, d_030, 1'b1);
        check("031 bubble b", 32'(out_valid), 0);

        // asynchronous reset while busy on grant 2
        do_reset();
        drive(4'b0100, d_030, 1'b0);
        drive(4'b0100, d_030, 1'b0);
        check("032 pre grant", 32'(grant_idx), 2);
        check("032 pre valid", 32'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("032 rst valid", 32'(out_valid), 0);
        check("032 rst grant", 32'(grant_idx), 0);
        check("032 rst data", 32'(out_data), 0);
        out_ready = 1'b1;
        #1;
        check("032 rst ready", 32'(req_ready), 0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b0110;
        out_ready = 1'b0;
        #1;
        check("032 post idle", 32'(out_valid), 0);
        drive(4'b0110, d_030, 1'b0);
        check("032 post grant", 32'(grant_idx), 1);
        check("032 post data", 32'(out_data), 32'h11);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
